// File: rtl/basic_xor_pulse_driver.sv
// Initiator for the basic XOR cell's toggle-encoded pulse interface.
// Each accepted (a,b) pair is sent as toggle pulses on a, then b, then clk.
// The pulses are spaced by GAP_CYCLES. The cell's toggle output is then
// counted over a fixed window, and the observed result is reported.
//
// Handshake: a pair transfers on a rising clk edge when in_valid && in_ready.
// in_ready is high only in IDLE, so at most one transaction is in flight and
// there is no skid buffer. The sender holds in_valid/in_a/in_b stable until
// the transfer. res_valid is a one-cycle strobe. res_data/res_err hold their
// values until the next strobe.
module basic_xor_pulse_driver #(
  parameter int GAP_CYCLES     = 3,
  parameter int OUT_TIMEOUT    = 8,
  parameter int STARTUP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_a,
  input  logic       in_b,
  output logic       pulse_a,
  output logic       pulse_b,
  output logic       pulse_clk,
  input  logic       cell_out,
  output logic       res_valid,
  output logic       res_data,
  output logic       res_err,
  output logic       stray_err,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    ST_STARTUP  = 4'd0,
    ST_IDLE     = 4'd1,
    ST_SEND_A   = 4'd2,
    ST_GAP_A    = 4'd3,
    ST_SEND_B   = 4'd4,
    ST_GAP_B    = 4'd5,
    ST_SEND_CLK = 4'd6,
    ST_WAIT_OUT = 4'd7,
    ST_RESULT   = 4'd8
  } state_t;

  localparam int CW = 8;
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST    = CW'(OUT_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            lat_b;
  logic            exp_tog;
  logic [1:0]      tog_cnt;
  logic [1:0]      tog_final;
  logic            sync_q, sync_qq;
  logic            toggle;
  logic            accept;
  logic            wait_done;
  logic            counting;

  assign toggle    = sync_q ^ sync_qq;
  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign res_valid = (state == ST_RESULT);
  assign dbg_state = state;
  assign wait_done = (state == ST_WAIT_OUT) && (cnt == WAIT_LAST);
  assign counting  = (state == ST_STARTUP) || (state == ST_GAP_A) ||
                     (state == ST_GAP_B) || (state == ST_WAIT_OUT);

  // Saturating count including a toggle seen on the current (possibly last) window cycle.
  assign tog_final = (toggle && (tog_cnt != 2'd3)) ? tog_cnt + 2'd1 : tog_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STARTUP;
    else     state <= state_nxt;
  end

  // Next-state sequencing of the pulse train and observation window.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP:  if (cnt == STARTUP_LAST) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          if (in_a)      state_nxt = ST_SEND_A;
          else if (in_b) state_nxt = ST_SEND_B;
          else           state_nxt = ST_SEND_CLK;
        end
      end
      ST_SEND_A:   state_nxt = ST_GAP_A;
      ST_GAP_A:    if (cnt == GAP_LAST) state_nxt = lat_b ? ST_SEND_B : ST_SEND_CLK;
      ST_SEND_B:   state_nxt = ST_GAP_B;
      ST_GAP_B:    if (cnt == GAP_LAST) state_nxt = ST_SEND_CLK;
      ST_SEND_CLK: state_nxt = ST_WAIT_OUT;
      ST_WAIT_OUT: if (wait_done) state_nxt = ST_RESULT;
      ST_RESULT:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_STARTUP;
    endcase
  end

  // Shared cycle counter: restarts on every state change, advances while dwelling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cnt <= '0;
    else if (state_nxt != state || !counting) cnt <= '0;
    else                                     cnt <= cnt + 1'b1;
  end

  // Two-flop synchronizer for the asynchronous cell output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
    end else begin
      sync_q  <= cell_out;
      sync_qq <= sync_q;
    end
  end

  // Pulse lines: each is inverted once on leaving its SEND state and never restored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_a   <= 1'b0;
      pulse_b   <= 1'b0;
      pulse_clk <= 1'b0;
    end else begin
      if (state == ST_SEND_A)   pulse_a   <= ~pulse_a;
      if (state == ST_SEND_B)   pulse_b   <= ~pulse_b;
      if (state == ST_SEND_CLK) pulse_clk <= ~pulse_clk;
    end
  end

  // Operand latch, toggle counting and result capture at the end of the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_b    <= 1'b0;
      exp_tog  <= 1'b0;
      tog_cnt  <= 2'd0;
      res_data <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        lat_b   <= in_b;
        exp_tog <= in_a ^ in_b;
        tog_cnt <= 2'd0;
      end else if (state == ST_WAIT_OUT) begin
        tog_cnt <= tog_final;
      end
      if (wait_done) begin
        res_data <= (tog_final == 2'd1);
        res_err  <= (tog_final != {1'b0, exp_tog});
      end
    end
  end

  // Sticky flag for cell output activity outside the observation window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stray_err <= 1'b0;
    else if (toggle && state != ST_WAIT_OUT)  stray_err <= 1'b1;
  end

endmodule

// File: tb/tb_basic_xor_pulse_driver.sv
// Bench for basic_xor_pulse_driver: directed scenarios plus random pairs,
// with a behavioural cell model and a scoreboard of expected results.
module tb_basic_xor_pulse_driver;

  localparam int GAP = 3;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_a = 1'b0;
  logic       in_b = 1'b0;
  logic       cell_out = 1'b0;
  logic       in_ready, pulse_a, pulse_b, pulse_clk;
  logic       res_valid, res_data, res_err, stray_err;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  basic_xor_pulse_driver #(
    .GAP_CYCLES(GAP), .OUT_TIMEOUT(TMO), .STARTUP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .pulse_a(pulse_a), .pulse_b(pulse_b),
    .pulse_clk(pulse_clk), .cell_out(cell_out), .res_valid(res_valid),
    .res_data(res_data), .res_err(res_err), .stray_err(stray_err),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- cell model ----------------
  // mode 0: healthy cell, 1: never toggles out, 2: toggles out twice.
  int   cell_mode [256];
  logic cell_x    [256];
  int   wr_idx = 0;
  int   rd_idx = 0;
  int   stray_req = 0;
  int   stray_done = 0;
  logic prev_pclk = 1'b0;
  int   cd1 = 0;
  int   cd2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      cell_out   = 1'b0;
      prev_pclk  = 1'b0;
      cd1        = 0;
      cd2        = 0;
      rd_idx     = wr_idx;
      stray_done = stray_req;
    end else begin
      if (cd1 > 0) begin
        cd1--;
        if (cd1 == 0) cell_out = ~cell_out;
      end
      if (cd2 > 0) begin
        cd2--;
        if (cd2 == 0) cell_out = ~cell_out;
      end
      if (stray_req != stray_done) begin
        cell_out = ~cell_out;
        stray_done++;
      end
      if (pulse_clk != prev_pclk) begin
        prev_pclk = pulse_clk;
        if (rd_idx != wr_idx) begin
          if (cell_x[rd_idx % 256] && cell_mode[rd_idx % 256] != 1) cd1 = 5;
          if (cell_x[rd_idx % 256] && cell_mode[rd_idx % 256] == 2) cd2 = 6;
          rd_idx++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q [$];   // {res_data, res_err}
  int         acc_q [$];   // cycle index of the accepting edge
  logic [1:0] ab_q  [$];   // {a, b}
  logic pa_prev = 1'b0, pb_prev = 1'b0, pc_prev = 1'b0;
  int   pa_n = 0, pb_n = 0, pc_n = 0;
  int   pa_c = 0, pb_c = 0, pc_c = 0;
  int   res_n = 0;

  always @(negedge clk) begin
    logic [1:0] e;
    logic [1:0] ab;
    int         acc;
    int         n;
    if (rst) begin
      pa_prev = 1'b0; pb_prev = 1'b0; pc_prev = 1'b0;
      pa_n = 0; pb_n = 0; pc_n = 0;
    end else begin
      if (pulse_a != pa_prev) begin pa_n++; pa_c = cyc; pa_prev = pulse_a; end
      if (pulse_b != pb_prev) begin pb_n++; pb_c = cyc; pb_prev = pulse_b; end
      if (pulse_clk != pc_prev) begin pc_n++; pc_c = cyc; pc_prev = pulse_clk; end
      if (res_valid) begin
        res_n++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", exp_q.size(), 1);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          ab  = ab_q.pop_front();
          n   = int'(ab[1]) + int'(ab[0]);
          check("res_data", res_data, e[1]);
          check("res_err", res_err, e[0]);
          check("latency", cyc - acc + 1, n * (1 + GAP) + 1 + TMO + 1);
          check("pulse_a_count", pa_n, ab[1]);
          check("pulse_b_count", pb_n, ab[0]);
          check("pulse_clk_count", pc_n, 1);
          check("clk_pulse_offset", pc_c - acc, 1 + n * (1 + GAP));
          if (ab[1]) check("a_pulse_offset", pa_c - acc, 1);
          if (ab[0]) check("b_pulse_offset", pb_c - acc, 1 + int'(ab[1]) * (1 + GAP));
          pa_n = 0; pb_n = 0; pc_n = 0;
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic a, input logic b, input int mode);
    int   t;
    int   tog;
    logic x;
    t = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      check("ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    x   = a ^ b;
    tog = (mode == 0) ? int'(x) : (mode == 1) ? 0 : 2 * int'(x);
    exp_q.push_back({(tog == 1), (tog != int'(x))});
    acc_q.push_back(cyc + 1);
    ab_q.push_back({a, b});
    cell_mode[wr_idx % 256] = mode;
    cell_x[wr_idx % 256]    = x;
    wr_idx++;
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 300) begin @(negedge clk); t++; end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulse_a"}, pulse_a, 0);
    check({tag, "_pulse_b"}, pulse_b, 0);
    check({tag, "_pulse_clk"}, pulse_clk, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_stray_err"}, stray_err, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    check("startup_ready_0", in_ready, 0);
    @(negedge clk);
    check("startup_ready_1", in_ready, 0);
    @(negedge clk);
    check("startup_ready_2", in_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete(); acc_q.delete(); ab_q.delete();
    check_reset_outputs("rst");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int res0;
    int r;
    @(negedge clk);
    do_reset();
    release_reset();

    // T1: reset in the middle of GAP_A
    send(1'b1, 1'b0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_pulse_a", pulse_a, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    exp_q.delete(); acc_q.delete(); ab_q.delete();
    @(negedge clk);
    release_reset();

    // T2..T4: single directed transactions
    send(1'b1, 1'b0, 0); in_valid = 1'b0; drain();
    send(1'b1, 1'b1, 0); in_valid = 1'b0; drain();
    send(1'b0, 1'b1, 1); in_valid = 1'b0; drain();
    send(1'b0, 1'b1, 2); in_valid = 1'b0; drain();
    send(1'b0, 1'b0, 0); in_valid = 1'b0; drain();

    // T5: stray toggle while idle is sticky until reset
    check("stray_before", stray_err, 0);
    stray_req++;
    repeat (4) @(negedge clk);
    check("stray_set", stray_err, 1);
    send(1'b1, 1'b0, 0); in_valid = 1'b0; drain();
    check("stray_sticky_1", stray_err, 1);
    send(1'b1, 1'b1, 0); in_valid = 1'b0; drain();
    check("stray_sticky_2", stray_err, 1);
    do_reset();
    release_reset();

    // T6: back-to-back pairs with in_valid held
    res0 = res_n;
    send(1'b0, 1'b0, 0);
    send(1'b0, 1'b1, 0);
    send(1'b1, 1'b0, 0);
    send(1'b1, 1'b1, 0);
    in_valid = 1'b0;
    drain();
    check("b2b_strobes", res_n - res0, 4);

    // Random pairs, cell behaviours and idle gaps
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           (r < 6) ? 0 : (r < 8) ? 1 : 2);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    drain();
    check("random_no_stray", stray_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
